// File: rtl/pipeline_pkg.sv
// Shared definitions for the 5-stage pipeline sequencing logic.
// Holds the controller state encoding, register-address defaults and
// the per-latch control word, including the bubble that every latch loads on flush.
package pipeline_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_STEP = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  localparam int REG_W_DEF = 5;

  // $zero never carries a real dependency, so it never causes a stall.
  localparam logic [REG_W_DEF-1:0] ZERO_REG = '0;

  // Load enable and flush for one pipeline latch. Flush wins over en in the
  // latch itself, and a flushed latch loads all-zero control bits.
  typedef struct packed {
    logic en;
    logic flush;
  } latch_ctl_t;

  localparam latch_ctl_t LATCH_HOLD   = '{en: 1'b0, flush: 1'b0};
  localparam latch_ctl_t LATCH_LOAD   = '{en: 1'b1, flush: 1'b0};
  localparam latch_ctl_t LATCH_BUBBLE = '{en: 1'b1, flush: 1'b1};
  localparam latch_ctl_t LATCH_RESET  = '{en: 1'b0, flush: 1'b1};

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: a load in EX whose rt feeds the instruction in ID.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the controller decides whether the hazard stalls.
// Ports: id_rs/id_rt (ID sources), ex_rt/ex_MemRead (load in EX) -> load_use.
module hazard_detect
  import pipeline_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_MemRead,
  output logic             load_use
);

  assign load_use = ex_MemRead
                 && (ex_rt != REG_W'(ZERO_REG))
                 && ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// Central sequencer for the 5-stage MIPS pipeline: latch enables/flushes and PC select.
// Latency: enables, flushes and pc_src are combinational; state and counters are registered.
// Backpressure: data-memory wait freezes every latch; timeout after TIMEOUT wait cycles is fatal.
// Ports: clk/reset; hazard inputs (id_rs, id_rt, ex_rt, ex_MemRead); branch (mem_Branch, mem_zero);
//        memory (mem_access, dmem_ready); debug (step_mode, step_pulse); latch controls, pc_src,
//        mem_err (sticky) and stall_cnt (saturating).
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int REG_W   = REG_W_DEF,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_MemRead,
  input  logic             mem_Branch,
  input  logic             mem_zero,
  input  logic             mem_access,
  input  logic             dmem_ready,
  input  logic             step_mode,
  input  logic             step_pulse,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic             pc_src,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              load_use;
  logic              advancing;
  logic              freeze;
  logic              branch_taken;
  logic              timeout;
  logic              stall_inc;
  latch_ctl_t        if_id_c, id_ex_c, ex_mem_c, mem_wb_c;

  hazard_detect #(.REG_W(REG_W)) u_hazard (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .ex_rt      (ex_rt),
    .ex_MemRead (ex_MemRead),
    .load_use   (load_use)
  );

  // Freeze and timeout only matter while the pipeline is allowed to advance;
  // HALT and ERR already hold every latch.
  assign advancing    = (state == ST_RUN) || (state == ST_STEP);
  assign freeze       = advancing && mem_access && !dmem_ready;
  assign branch_taken = mem_Branch && mem_zero;
  assign timeout      = freeze && (wait_cnt == WAIT_W'(TIMEOUT - 1));
  // A taken branch squashes the load-use pair, so it is not a stall cycle.
  assign stall_inc    = freeze || (advancing && !branch_taken && load_use);

  // Output mux: freeze > branch > load-use > normal flow.
  always_comb begin
    pc_en    = 1'b0;
    pc_src   = 1'b0;
    if_id_c  = LATCH_HOLD;
    id_ex_c  = LATCH_HOLD;
    ex_mem_c = LATCH_HOLD;
    mem_wb_c = LATCH_HOLD;
    if (reset) begin
      // Latches have no reset; bubble them on every reset edge.
      if_id_c  = LATCH_RESET;
      id_ex_c  = LATCH_RESET;
      ex_mem_c = LATCH_RESET;
      mem_wb_c = LATCH_RESET;
    end else if (advancing && !freeze) begin
      pc_en    = 1'b1;
      if_id_c  = LATCH_LOAD;
      id_ex_c  = LATCH_LOAD;
      ex_mem_c = LATCH_LOAD;
      mem_wb_c = LATCH_LOAD;
      if (branch_taken) begin
        pc_src   = 1'b1;
        if_id_c  = LATCH_BUBBLE;
        id_ex_c  = LATCH_BUBBLE;
        ex_mem_c = LATCH_BUBBLE;
      end else if (load_use) begin
        pc_en    = 1'b0;
        if_id_c  = LATCH_HOLD;
        id_ex_c  = LATCH_BUBBLE;
      end
    end
  end

  assign if_id_en     = if_id_c.en;
  assign if_id_flush  = if_id_c.flush;
  assign id_ex_en     = id_ex_c.en;
  assign id_ex_flush  = id_ex_c.flush;
  assign ex_mem_en    = ex_mem_c.en;
  assign ex_mem_flush = ex_mem_c.flush;
  assign mem_wb_en    = mem_wb_c.en;
  assign mem_wb_flush = mem_wb_c.flush;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (timeout)                 state_nxt = ST_ERR;
        else if (step_mode && !freeze) state_nxt = ST_HALT;
      end
      ST_HALT: begin
        if (!step_mode)       state_nxt = ST_RUN;
        else if (step_pulse)  state_nxt = ST_STEP;
      end
      ST_STEP: begin
        // Stay in STEP until the single advance actually happens.
        if (timeout)      state_nxt = ST_ERR;
        else if (!freeze) state_nxt = ST_HALT;
      end
      default: state_nxt = ST_ERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= step_mode ? ST_HALT : ST_RUN;
      wait_cnt  <= '0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (freeze && !timeout) wait_cnt <= wait_cnt + 1'b1;
      else                    wait_cnt <= '0;
      if (timeout) mem_err <= 1'b1;
      if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central sequencing controller for the 5-stage MIPS pipeline. It drives the enable and flush lines of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB latches, and it resolves three conditions:
- load-use hazards, by stalling;
- taken branches resolved in MEM, by flushing;
- data-memory wait states, by freezing the pipeline, with a timeout.

It also provides a debug single-step mode and a saturating stall counter. The pipeline latches have no reset of their own, so this block flushes all of them while reset is asserted.

## Interface
Parameters:
- REG_W, 5, register-address width
- TIMEOUT, 255, maximum consecutive data-memory wait cycles before error (≥2)
- CNT_W, 16, stall-counter width

Ports:
- clk  in  1  pipeline clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- id_rs, id_rt  in  REG_W each  source registers of the instruction in ID
- ex_rt  in  REG_W  rt of the instruction in EX
- ex_MemRead  in  1  instruction in EX is a load
- mem_Branch, mem_zero  in  1 each  branch flag and zero flag from the EX/MEM latch
- mem_access  in  1  MemRead or MemWrite is active in MEM
- dmem_ready  in  1  data memory completes the access this cycle
- step_mode, step_pulse  in  1 each  debug halt enable; one-cycle advance request
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  latch load enables
- if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  load a bubble (all control bits 0); flush has priority over en
- pc_src  out  1  select the branch target (mem add_result) for the PC
- mem_err  out  1  sticky data-memory timeout
- stall_cnt  out  CNT_W  saturating count of stall and freeze cycles

## Operation
FSM states:
- RUN: normal operation.
- HALT: debug halted.
- STEP: one debug advance.
- ERR: dead after a timeout.

Per-cycle output priority when advancing (RUN or STEP):
1. Freeze: mem_access=1 and dmem_ready=0. All enables 0, no flush, pc_src=0.
2. Branch taken: mem_Branch=1 and mem_zero=1. pc_src=1; if_id_flush, id_ex_flush and ex_mem_flush are 1; all enables 1.
3. Load-use: ex_MemRead=1, ex_rt≠0, and ex_rt equals id_rs or id_rt. pc_en=0, if_id_en=0, id_ex_flush=1; other enables 1.
4. Otherwise all enables 1, no flush, pc_src=0.

A branch overrides a load-use stall, because the stalled instructions are flushed anyway.

Other states:
- HALT: all enables 0, no flush, pc_src=0.
- ERR: same as HALT, and mem_err=1.

Transitions:
- RUN→HALT when step_mode=1 and the cycle is not a freeze.
- HALT→RUN when step_mode=0.
- HALT→STEP when step_pulse=1.
- STEP→HALT after one non-freeze cycle. STEP remains in STEP while frozen.
- Any state except ERR→ERR on timeout.
- ERR is left only by reset.

Wait counter:
- Counts consecutive freeze cycles.
- Clears on any non-freeze cycle.
- The cycle in which it reaches TIMEOUT-1 with dmem_ready still 0 sets mem_err and moves the state to ERR.

stall_cnt:
- Increments on each freeze or load-use cycle; a branch cycle does not count.
- Saturates at all ones and is cleared only by reset.

## Timing
- All enable, flush and pc_src outputs are combinational from the current state and inputs, with zero latency, so they are valid before the posedge that latches them.
- State, wait counter, mem_err and stall_cnt are registered.

While reset=1:
- pc_en=0 and all other enables 0.
- All four flushes are 1, so the latches load bubbles on every reset edge.
- pc_src=0.

Reset values:
- state = HALT if step_mode=1 at the reset edge, else RUN.
- wait counter = 0, mem_err = 0, stall_cnt = 0.

Boundary behaviour:
- Reset asserted mid-freeze or in ERR has priority and recovers to RUN/HALT on the next edge.
- step_pulse is ignored outside HALT.
- A step_pulse held for several cycles advances once per HALT→STEP→HALT round trip.
- Freeze during branch or load-use: the freeze wins. The branch is re-evaluated on the cycle after dmem_ready, because the EX/MEM latch holds its value.

## Structure
- The shared package pipeline_pkg holds:
  - state encoding for RUN, HALT, STEP and ERR;
  - REG_W default;
  - the zero-register constant;
  - the bubble (all-zero control) definition used by every latch.
- Sub-module hazard_detect is purely combinational. It takes id_rs, id_rt, ex_rt and ex_MemRead and produces load_use. The FSM, counters and output mux stay in pipeline_ctrl.

## Test plan
- Reset sequence:
  - Stimulus: reset=1 for 2 cycles with step_mode=0.
  - Required response: all flushes 1 and all enables 0 during reset; state RUN afterwards with all enables 1; stall_cnt=0.
- Load-use stall:
  - Stimulus: ex_MemRead=1, ex_rt=8, id_rs=8.
  - Required response: pc_en=0, if_id_en=0, id_ex_flush=1; stall_cnt increments by 1.
  - Repeat with ex_rt=0: no stall.
- Branch over load-use:
  - Stimulus: mem_Branch=1, mem_zero=1, with a simultaneous load-use on r8.
  - Required response: pc_src=1; IF/ID, ID/EX and EX/MEM flushes are 1; all enables 1; stall_cnt unchanged.
- Memory freeze:
  - Stimulus: mem_access=1, dmem_ready=0 for 3 cycles, then 1.
  - Required response: all enables 0 for 3 cycles, then 1; stall_cnt=3.
  - With TIMEOUT=4 and dmem_ready held at 0: mem_err rises on the 4th freeze cycle, state is ERR, and only reset clears it.
- Single step:
  - Stimulus: step_mode=1, then step_pulse=1 for 1 cycle.
  - Required response: exactly one cycle with enables 1, then HALT.
  - With a freeze during STEP: the advance occurs on the dmem_ready cycle.
